// File: rtl/img_pkg.sv
// Shared constants, filter codes and FSM encoding for the image filter engine.
package img_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    FLT_PASS  = 3'd0,
    FLT_ADD   = 3'd1,
    FLT_SUB   = 3'd2,
    FLT_INV   = 3'd3,
    FLT_BLUR  = 3'd4,
    FLT_EDGE  = 3'd5,
    FLT_SHARP = 3'd6,
    FLT_THR   = 3'd7
  } flt_e;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_READ  = 3'd1;
  localparam state_t S_LAST  = 3'd2;
  localparam state_t S_WRITE = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  function automatic logic [7:0] sat8(input logic signed [12:0] x);
    if (x < 13'sd0) begin
      return 8'd0;
    end else if (x > 13'sd255) begin
      return 8'd255;
    end else begin
      return x[7:0];
    end
  endfunction

endpackage

// File: rtl/filter_alu.sv
// Combinational 3x3 window filter; window slot k holds neighbour (k/3-1, k%3-1).
module filter_alu
  import img_pkg::*;
(
  input  logic [8:0][DATA_W-1:0] win,
  input  flt_e                   code,
  input  logic [DATA_W-1:0]      val,
  output logic [DATA_W-1:0]      result
);

  function automatic logic signed [12:0] ext(input logic [7:0] p);
    return $signed({5'b0, p});
  endfunction

  logic signed [12:0] c, v, nsew, diag, acc;

  always_comb begin
    c    = ext(win[4]);
    v    = ext(val);
    nsew = ext(win[1]) + ext(win[3]) + ext(win[5]) + ext(win[7]);
    diag = ext(win[0]) + ext(win[2]) + ext(win[6]) + ext(win[8]);
    acc  = c;
    case (code)
      FLT_PASS:  acc = c;
      FLT_ADD:   acc = c + v;
      FLT_SUB:   acc = c - v;
      FLT_INV:   acc = 13'sd255 - c;
      FLT_BLUR:  acc = (13'sd4 * c + 13'sd2 * nsew + diag) >>> 4;
      FLT_EDGE: begin
        acc = 13'sd8 * c - (nsew + diag);
        if (acc < 13'sd0) acc = -acc;
      end
      FLT_SHARP: acc = 13'sd5 * c - nsew;
      FLT_THR:   acc = (c >= v) ? 13'sd255 : 13'sd0;
      default:   acc = c;
    endcase
    result = sat8(acc);
  end

endmodule

// File: rtl/image_filter_engine.sv
// Full-frame 3x3 filter pass: reads the source BRAM, writes the display frame buffer.
module image_filter_engine #(
  parameter int IMG_W  = img_pkg::IMG_W,
  parameter int IMG_H  = img_pkg::IMG_H,
  parameter int ADDR_W = img_pkg::ADDR_W,
  parameter int DATA_W = img_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        sel_module,
  input  logic [7:0]        val,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst_data,
  output logic              dst_we,
  output logic              busy,
  output logic              done
);

  import img_pkg::*;

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_t                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [3:0]              k_q, k_d;
  logic [ADDR_W-1:0]       src_addr_q, src_addr_d;
  logic [ADDR_W-1:0]       dst_addr_q;
  logic [DATA_W-1:0]       dst_data_q;
  logic                    dst_we_q, busy_q, done_q;
  flt_e                    sel_q;
  logic [7:0]              val_q;
  logic [8:0][DATA_W-1:0]  win_q, alu_win;
  logic [DATA_W-1:0]       alu_res;
  logic                    last_px;

  // Neighbour address with edge replication by clamping row and column.
  function automatic logic [ADDR_W-1:0] nb_addr(input logic [ROW_W-1:0] r,
                                                input logic [COL_W-1:0] c,
                                                input logic [3:0]       k);
    int rr, cc;
    rr = int'(r) + int'(k) / 3 - 1;
    cc = int'(c) + int'(k) % 3 - 1;
    if (rr < 0) rr = 0;
    if (rr > IMG_H - 1) rr = IMG_H - 1;
    if (cc < 0) cc = 0;
    if (cc > IMG_W - 1) cc = IMG_W - 1;
    return ADDR_W'(rr * IMG_W + cc);
  endfunction

  assign last_px = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    k_d        = k_q;
    src_addr_d = src_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_READ;
          row_d      = '0;
          col_d      = '0;
          k_d        = 4'd0;
          src_addr_d = nb_addr('0, '0, 4'd0);
        end
      end
      S_READ: begin
        if (k_q == 4'd8) begin
          state_d = S_LAST;
        end else begin
          k_d        = k_q + 4'd1;
          src_addr_d = nb_addr(row_q, col_q, k_q + 4'd1);
        end
      end
      S_LAST: state_d = S_WRITE;
      S_WRITE: begin
        k_d = 4'd0;
        if (last_px) begin
          state_d = S_DONE;
          row_d   = '0;
          col_d   = '0;
        end else begin
          col_d = col_q + 1'b1;
          if (col_q == COL_W'(IMG_W - 1)) row_d = row_q + 1'b1;
          state_d    = S_READ;
          src_addr_d = nb_addr(row_d, col_d, 4'd0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The last window slot arrives in LAST, so the ALU sees it straight from the BRAM.
  always_comb begin
    alu_win    = win_q;
    alu_win[8] = src_data;
  end

  filter_alu u_alu (
    .win    (alu_win),
    .code   (sel_q),
    .val    (val_q),
    .result (alu_res)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      dst_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_q      <= FLT_PASS;
      val_q      <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      k_q        <= k_d;
      src_addr_q <= src_addr_d;
      if (state_q == S_IDLE && start) begin
        sel_q <= flt_e'(sel_module);
        val_q <= val;
      end
      if (state_q == S_READ && k_q != 4'd0) win_q[k_q - 4'd1] <= src_data;
      if (state_q == S_LAST) begin
        win_q[8]   <= src_data;
        dst_addr_q <= ADDR_W'(int'(row_q) * IMG_W + int'(col_q));
        dst_data_q <= alu_res;
      end
      dst_we_q <= (state_q == S_LAST);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign src_addr = src_addr_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;
  assign dst_we   = dst_we_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_image_filter_engine.sv
// Self-checking bench for image_filter_engine on a reduced 16x16 frame.
module tb_image_filter_engine;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int N  = W * H;
  localparam int AW = 8;

  logic          clock, reset, start;
  logic [2:0]    sel_module;
  logic [7:0]    val;
  logic [AW-1:0] src_addr, dst_addr;
  logic [7:0]    src_data, dst_data;
  logic          dst_we, busy, done;

  image_filter_engine #(
    .IMG_W  (W),
    .IMG_H  (H),
    .ADDR_W (AW),
    .DATA_W (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .sel_module (sel_module),
    .val        (val),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .dst_addr   (dst_addr),
    .dst_data   (dst_data),
    .dst_we     (dst_we),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] mem [N];
  logic [7:0] fb  [N];
  always @(posedge clock) src_data <= mem[src_addr];

  typedef struct {
    int pat;     // 0 ramp, 1 constant fill, 2 single bright dot at centre
    int fill;
    int code;
    int v;
    int inject;  // re-pulse start while busy and in the DONE cycle
    int r1, c1, e1;
    int r2, c2, e2;
  } vec_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;

  vec_t tbl [7];
  exp_t sbq [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_cnt;
  int   cyc;
  int   got_done;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int ref_pix(input int r, input int c, input int code, input int v);
    int p [9];
    int rr, cc, ctr, nsew, diag, acc;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
      rr = (rr < 0) ? 0 : (rr > H - 1) ? H - 1 : rr;
      cc = (cc < 0) ? 0 : (cc > W - 1) ? W - 1 : cc;
      p[k] = int'(mem[rr * W + cc]);
    end
    ctr  = p[4];
    nsew = p[1] + p[3] + p[5] + p[7];
    diag = p[0] + p[2] + p[6] + p[8];
    case (code)
      0:       acc = ctr;
      1:       acc = ctr + v;
      2:       acc = ctr - v;
      3:       acc = 255 - ctr;
      4:       acc = (4 * ctr + 2 * nsew + diag) / 16;
      5: begin
        acc = 8 * ctr - nsew - diag;
        if (acc < 0) acc = -acc;
      end
      6:       acc = 5 * ctr - nsew;
      default: acc = (ctr >= v) ? 255 : 0;
    endcase
    if (acc < 0) acc = 0;
    if (acc > 255) acc = 255;
    return acc;
  endfunction

  task automatic load_mem(input int pat, input int fill);
    for (int i = 0; i < N; i++) begin
      case (pat)
        0:       mem[i] = 8'(i);
        1:       mem[i] = 8'(fill);
        default: mem[i] = (i == 8 * W + 8) ? 8'd255 : 8'd0;
      endcase
    end
  endtask

  task automatic mon();
    exp_t e;
    if (dst_we) begin
      wr_cnt++;
      fb[dst_addr] = dst_data;
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("px_addr", int'(dst_addr), int'(e.a));
        chk("px_data", int'(dst_data), int'(e.d));
      end
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_src_addr"}, int'(src_addr), 0);
    chk({nm, "_dst_addr"}, int'(dst_addr), 0);
    chk({nm, "_dst_data"}, int'(dst_data), 0);
    chk({nm, "_dst_we"},   int'(dst_we),   0);
    chk({nm, "_busy"},     int'(busy),     0);
    chk({nm, "_done"},     int'(done),     0);
  endtask

  initial begin
    exp_t e;
    tbl[0] = '{0,   0, 0,   0, 0, 15, 15, 255,  0,  5,   5};
    tbl[1] = '{1, 200, 1, 100, 0,  3,  5, 255, 15,  0, 255};
    tbl[2] = '{1, 200, 2, 250, 0,  0,  0,   0, 15, 15,   0};
    tbl[3] = '{2,   0, 5,   0, 0,  8,  8, 255,  7,  7, 255};
    tbl[4] = '{1,  77, 4,   0, 0,  0,  0,  77, 15, 15,  77};
    tbl[5] = '{1,  77, 6,   0, 0,  0,  0,  77, 15, 15,  77};
    tbl[6] = '{0,   0, 7, 128, 1,  7, 15,   0,  8,  0, 255};

    reset      = 1'b1;
    start      = 1'b0;
    sel_module = 3'd0;
    val        = 8'd0;
    load_mem(0, 0);
    repeat (3) @(negedge clock);
    chk_all_zero("reset_state");
    reset = 1'b0;

    // Abort a pass midway, then restart and time the first write.
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (1000) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("mid_reset");
    reset = 1'b0;
    @(negedge clock);
    sel_module = 3'd0;
    start      = 1'b1;
    @(posedge clock);
    cyc = 1;
    @(negedge clock);
    start = 1'b0;
    while (cyc < 40 && !dst_we) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
    chk("first_we_cycle", cyc, 11);
    chk("first_we_addr", int'(dst_addr), 0);
    chk("first_we_data", int'(dst_data), 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    for (int t = 0; t < 7; t++) begin
      load_mem(tbl[t].pat, tbl[t].fill);
      for (int i = 0; i < N; i++) fb[i] = 8'hxx;
      sbq.delete();
      for (int a = 0; a < N; a++) begin
        e.a = 8'(a);
        e.d = 8'(ref_pix(a / W, a % W, tbl[t].code, tbl[t].v));
        sbq.push_back(e);
      end
      @(negedge clock);
      sel_module = 3'(tbl[t].code);
      val        = 8'(tbl[t].v);
      start      = 1'b1;
      @(posedge clock);
      cyc = 1;
      @(negedge clock);
      start      = 1'b0;
      sel_module = 3'($urandom);
      val        = 8'($urandom);
      wr_cnt     = 0;
      got_done   = 0;
      while (cyc <= 11 * N + 20) begin
        mon();
        if (done) begin
          got_done = 1;
          break;
        end
        start = (tbl[t].inject != 0 && (cyc == 40 || cyc == 900));
        @(posedge clock);
        cyc++;
        @(negedge clock);
      end
      start = 1'b0;
      chk("done_seen", got_done, 1);
      chk("done_cycle", cyc, 11 * N + 1);
      chk("write_count", wr_cnt, N);
      chk("sb_leftover", sbq.size(), 0);
      start = (tbl[t].inject != 0);
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      chk("done_width", int'(done), 0);
      chk("busy_after", int'(busy), 0);
      repeat (3) @(negedge clock);
      chk("stays_idle", int'(busy), 0);
      chk("spot1", int'(fb[tbl[t].r1 * W + tbl[t].c1]), tbl[t].e1);
      chk("spot2", int'(fb[tbl[t].r2 * W + tbl[t].c2]), tbl[t].e2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
